// File: rtl/opr_pkg.sv
// Shared types for the PDP-8 group-1 operate sequencer: phase encoding, latched
// command bits and the rule that picks the next executed phase.
package opr_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_CMP  = 3'd2,
    ST_INC  = 3'd3,
    ST_ROT1 = 3'd4,
    ST_ROT2 = 3'd5,
    ST_DONE = 3'd6
  } state_e;

  typedef struct packed {
    logic cla;
    logic cll;
    logic cma;
    logic cml;
    logic iac;
    logic ral;
    logic rar;
    logic twice;
  } cmd_t;

  localparam cmd_t CMD_NONE = '0;

  // Skipped phases fall through to the next one in event-time order.
  // RAL and RAR together cancel, so the ring is left untouched.
  function automatic state_e next_phase(input state_e cur, input cmd_t c);
    logic   do_cmp;
    logic   do_inc;
    logic   do_rot;
    state_e nxt;
    do_cmp = c.cma | c.cml;
    do_inc = c.iac;
    do_rot = c.ral ^ c.rar;
    nxt    = ST_DONE;
    case (cur)
      ST_CLR: begin
        if (do_cmp)      nxt = ST_CMP;
        else if (do_inc) nxt = ST_INC;
        else if (do_rot) nxt = ST_ROT1;
      end
      ST_CMP: begin
        if (do_inc)      nxt = ST_INC;
        else if (do_rot) nxt = ST_ROT1;
      end
      ST_INC: begin
        if (do_rot) nxt = ST_ROT1;
      end
      ST_ROT1: begin
        if (c.twice) nxt = ST_ROT2;
      end
      default: nxt = ST_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/opr_group1_seq_link_rotate.sv
// One-position rotate of the WIDTH+1 bit {L,AC} ring; dir=1 rotates right.
module link_rotate #(
  parameter int WIDTH = 12
) (
  input  logic [WIDTH-1:0] ac_in,
  input  logic             l_in,
  input  logic             dir,
  output logic [WIDTH-1:0] ac_out,
  output logic             l_out
);

  always_comb begin
    if (dir) begin
      l_out  = ac_in[0];
      ac_out = {l_in, ac_in[WIDTH-1:1]};
    end else begin
      l_out  = ac_in[WIDTH-1];
      ac_out = {ac_in[WIDTH-2:0], l_in};
    end
  end

endmodule

// File: rtl/opr_group1_seq.sv
// Sequenced PDP-8 group-1 operate unit: clear/OR, complement, increment and
// rotate run as one-cycle phases on a registered {L,AC}, ending in a DONE pulse.
module opr_group1_seq #(
  parameter int WIDTH = 12
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [WIDTH-1:0] AC_IN,
  input  logic             L_IN,
  input  logic [WIDTH-1:0] DOR,
  input  logic             CLA,
  input  logic             CLL,
  input  logic             CMA,
  input  logic             CML,
  input  logic             IAC,
  input  logic             RAL,
  input  logic             RAR,
  input  logic             TWICE,
  output logic [WIDTH-1:0] AC_OUT,
  output logic             L_OUT,
  output logic             BUSY,
  output logic             DONE
);
  import opr_pkg::*;

  state_e           state_q, state_d;
  cmd_t             cmd_q, cmd_d;
  logic [WIDTH-1:0] ac_q, ac_d;
  logic             l_q, l_d;
  logic [WIDTH-1:0] dor_q, dor_d;

  logic             accept;
  logic [WIDTH:0]   inc_sum;
  logic [WIDTH-1:0] rot_ac;
  logic             rot_l;

  link_rotate #(.WIDTH(WIDTH)) u_rotate (
    .ac_in  (ac_q),
    .l_in   (l_q),
    .dir    (cmd_q.rar),
    .ac_out (rot_ac),
    .l_out  (rot_l)
  );

  // The carry out of the AC increment is what toggles the link.
  assign inc_sum = {1'b0, ac_q} + {{WIDTH{1'b0}}, 1'b1};
  assign accept  = START && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    ac_d    = ac_q;
    l_d     = l_q;
    dor_d   = dor_q;
    case (state_q)
      ST_IDLE: state_d = ST_IDLE;
      ST_CLR: begin
        ac_d    = (cmd_q.cla ? '0 : ac_q) | dor_q;
        l_d     = cmd_q.cll ? 1'b0 : l_q;
        state_d = next_phase(ST_CLR, cmd_q);
      end
      ST_CMP: begin
        ac_d    = cmd_q.cma ? ~ac_q : ac_q;
        l_d     = l_q ^ cmd_q.cml;
        state_d = next_phase(ST_CMP, cmd_q);
      end
      ST_INC: begin
        ac_d    = inc_sum[WIDTH-1:0];
        l_d     = l_q ^ inc_sum[WIDTH];
        state_d = next_phase(ST_INC, cmd_q);
      end
      ST_ROT1, ST_ROT2: begin
        ac_d    = rot_ac;
        l_d     = rot_l;
        state_d = next_phase(state_q, cmd_q);
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    // A request taken in DONE overrides the return to IDLE, giving no gap.
    if (accept) begin
      ac_d    = AC_IN;
      l_d     = L_IN;
      dor_d   = DOR;
      cmd_d   = '{cla: CLA, cll: CLL, cma: CMA, cml: CML,
                  iac: IAC, ral: RAL, rar: RAR, twice: TWICE};
      state_d = ST_CLR;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_NONE;
      ac_q    <= '0;
      l_q     <= 1'b0;
      dor_q   <= '0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      ac_q    <= ac_d;
      l_q     <= l_d;
      dor_q   <= dor_d;
    end
  end

  assign AC_OUT = ac_q;
  assign L_OUT  = l_q;
  assign BUSY   = (state_q != ST_IDLE) && (state_q != ST_DONE);
  assign DONE   = (state_q == ST_DONE);

endmodule
